// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight predicted branches: trains the predictor and raises a mispredict/redirect on resolve.
// Optional feature macro: BRQ_STATS_EN adds saturating resolve / mispredict counters.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid,
    input  logic [PC_W-1:0]          fetch_pc,
    input  logic                     fetch_pred,
    output logic                     fetch_ready,
    input  logic                     ex_valid,
    input  logic                     ex_taken,
    input  logic [PC_W-1:0]          ex_target,
    output logic                     upd_valid,
    output logic [IDX_W-1:0]         upd_index,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [PC_W-1:0]          redirect_pc,
    output logic                     resolve_err,
    output logic [$clog2(DEPTH):0]   count
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]              stat_branches,
    output logic [15:0]              stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);

    // Sequential fall-through address of a not-taken branch, wrapping at PC_W.
    function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

    logic [PC_W-1:0]  pc_mem_r   [DEPTH];
    logic             pred_mem_r [DEPTH];
    logic [PTR_W-1:0] head_r, tail_r;
    logic [CNT_W-1:0] count_r;

    logic             upd_valid_r, upd_taken_r, mispredict_r, resolve_err_r;
    logic [IDX_W-1:0] upd_index_r;
    logic [PC_W-1:0]  redirect_pc_r;

    logic             fetch_ready_s, enq_s, res_s, mis_s, empty_res_s;
    logic [PC_W-1:0]  head_pc_s, redirect_s;
    logic             head_pred_s;
    logic [CNT_W-1:0] count_next_s;
    logic [PTR_W-1:0] head_next_s, tail_next_s;

    assign fetch_ready_s = (count_r < CNT_DEPTH);

    // Decode this cycle's enqueue/resolve/flush and the next pointer/occupancy state.
    always_comb begin
        head_pc_s    = pc_mem_r[head_r];
        head_pred_s  = pred_mem_r[head_r];
        enq_s        = fetch_valid && fetch_ready_s;
        res_s        = ex_valid && (count_r != {CNT_W{1'b0}});
        empty_res_s  = ex_valid && (count_r == {CNT_W{1'b0}});
        mis_s        = res_s && (head_pred_s != ex_taken);
        redirect_s   = next_seq_pc(head_pc_s);
        count_next_s = count_r;
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        if (ex_taken) begin
            redirect_s = ex_target;
        end else begin
            redirect_s = next_seq_pc(head_pc_s);
        end
        if (mis_s) begin
            // Younger entries, and any same-cycle fetch, are wrong-path.
            count_next_s = {CNT_W{1'b0}};
            head_next_s  = {PTR_W{1'b0}};
            tail_next_s  = {PTR_W{1'b0}};
        end else begin
            if (enq_s) begin
                tail_next_s = tail_r + PTR_ONE;
            end else begin
                tail_next_s = tail_r;
            end
            if (res_s) begin
                head_next_s = head_r + PTR_ONE;
            end else begin
                head_next_s = head_r;
            end
            case ({enq_s, res_s})
                2'b10:   count_next_s = count_r + CNT_ONE;
                2'b01:   count_next_s = count_r - CNT_ONE;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq_s && !mis_s) begin
            pc_mem_r[tail_r]   <= fetch_pc;
            pred_mem_r[tail_r] <= fetch_pred;
        end
    end

    // Pointers, occupancy and registered resolve outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            upd_valid_r   <= 1'b0;
            upd_index_r   <= {IDX_W{1'b0}};
            upd_taken_r   <= 1'b0;
            mispredict_r  <= 1'b0;
            redirect_pc_r <= {PC_W{1'b0}};
            resolve_err_r <= 1'b0;
        end else begin
            head_r        <= head_next_s;
            tail_r        <= tail_next_s;
            count_r       <= count_next_s;
            upd_valid_r   <= res_s;
            mispredict_r  <= mis_s;
            resolve_err_r <= empty_res_s;
            if (res_s) begin
                upd_index_r   <= head_pc_s[IDX_W-1:0];
                upd_taken_r   <= ex_taken;
                redirect_pc_r <= redirect_s;
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [15:0] stat_branches_r, stat_mispred_r;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_r <= 16'h0000;
            stat_mispred_r  <= 16'h0000;
        end else begin
            if (res_s && (stat_branches_r != 16'hFFFF)) begin
                stat_branches_r <= stat_branches_r + 16'h0001;
            end
            if (mis_s && (stat_mispred_r != 16'hFFFF)) begin
                stat_mispred_r <= stat_mispred_r + 16'h0001;
            end
        end
    end

    assign stat_branches = stat_branches_r;
    assign stat_mispred  = stat_mispred_r;
`endif

    assign fetch_ready = fetch_ready_s;
    assign upd_valid   = upd_valid_r;
    assign upd_index   = upd_index_r;
    assign upd_taken   = upd_taken_r;
    assign mispredict  = mispredict_r;
    assign redirect_pc = redirect_pc_r;
    assign resolve_err = resolve_err_r;
    assign count       = count_r;

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight predicted branches, between fetch and execute. Fetch pushes each branch's PC and its 2-bit-predictor direction; execute resolves the oldest entry with the real outcome. The block emits a registered predictor-update strobe (table index plus actual direction) that drives the predictor's training port. On a wrong direction it emits a registered mispredict/redirect and flushes all younger entries.

## Interface
- `DEPTH`, default 4, number of entries; power of two, 2..16
- `IDX_W`, default 4, predictor index width; the index is `pc[IDX_W-1:0]`
- `PC_W`, default 32, PC width
- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `fetch_valid`  in  1  branch fetched this cycle
- `fetch_pc`  in  PC_W  branch PC
- `fetch_pred`  in  1  predicted direction (1 = taken)
- `fetch_ready`  out  1  queue can accept; equals `count < DEPTH`
- `ex_valid`  in  1  oldest branch resolved this cycle
- `ex_taken`  in  1  actual direction
- `ex_target`  in  PC_W  taken target
- `upd_valid`  out  1  one-cycle predictor-update strobe
- `upd_index`  out  IDX_W  predictor index of the resolved branch
- `upd_taken`  out  1  actual direction for training
- `mispredict`  out  1  one-cycle strobe; prediction was wrong
- `redirect_pc`  out  PC_W  correct next PC; valid while `mispredict`=1
- `resolve_err`  out  1  one-cycle strobe; `ex_valid` arrived with the queue empty
- `count`  out  clog2(DEPTH)+1  occupancy

## Operation
- Storage: circular buffer of {pc, pred}, with head and tail pointers that wrap modulo DEPTH, plus a `count` register.
- Enqueue fires when `fetch_valid && fetch_ready`. It writes to the tail and advances the tail.
- Resolve fires when `ex_valid && count != 0`. It reads the head and advances the head.
- The resolve result is registered into the outputs:
  - `upd_valid` = 1
  - `upd_index` = head pc[IDX_W-1:0]
  - `upd_taken` = `ex_taken`
  - `mispredict` = (head pred != `ex_taken`)
  - `redirect_pc` = `ex_taken` ? `ex_target` : head pc + 4, truncated to PC_W with wrap-around
- On a mispredicting resolve the block flushes:
  - head and tail are reset, and `count` becomes 0 at the same edge.
  - an enqueue in that same cycle is discarded, because it is a wrong-path instruction.
- Enqueue and non-mispredicting resolve in the same cycle: both happen and `count` is unchanged. This is allowed when full, but `fetch_ready` is still 0 when full, so no enqueue is accepted.
- `ex_valid` with `count == 0`: no state change, `resolve_err` = 1 next cycle, `upd_valid` stays 0. An enqueue in that same cycle is still accepted.
- `fetch_valid` while full: ignored, with no error flagged.
- Reset values: all outputs 0, `count` 0, pointers 0, `fetch_ready` 1. Reset asserted in the middle of operation discards all entries. Any strobe that was due is not produced.

## Timing
- Enqueue-to-resolvable latency is 1 cycle: an entry written at edge N can be resolved with `ex_valid` in cycle N+1.
- `upd_*`, `mispredict`, `redirect_pc` and `resolve_err` are registered and asserted in the cycle after `ex_valid`. Each is high for exactly one cycle unless a resolve occurs again.
- The flush is visible in `count` in the cycle after the mispredicting `ex_valid`. This is the same cycle `mispredict` is high.
- `fetch_ready` is derived combinationally from registered `count` only. It has no combinational path from any input.
- Back-to-back resolves at one per cycle are supported.

## Configuration
- `BRQ_STATS_EN` defined adds two 16-bit outputs:
  - `stat_branches`: counts resolves.
  - `stat_mispred`: counts mispredicting resolves.
  - Both saturate at 16'hFFFF, clear on `reset`, and update on the same edge as the strobes.
- `BRQ_STATS_EN` undefined: the ports and counters are absent, and there is no other behavioural change.

## Test plan
- Reset, then push pc=0x40 with pred=1, then resolve with taken=1 → next cycle `upd_valid`=1, `upd_index`=0x0, `upd_taken`=1, `mispredict`=0, `count`=0.
- Push pc=0x44 with pred=1, then resolve with taken=0 → `mispredict`=1, `redirect_pc`=0x48, `upd_taken`=0.
- Fill with 4 entries → `fetch_ready`=0. Push a 5th → dropped. Resolve all 4 → indices are returned in FIFO order and both pointers wrap.
- 3 entries queued; in one cycle the head mispredicts (pred=0, taken=1, target=0x100) while `fetch_valid`=1 → `redirect_pc`=0x100, `count`=0 next cycle, and the new entry is discarded.
- `ex_valid`=1 with the queue empty → `resolve_err`=1 for one cycle, `upd_valid`=0.
- With `BRQ_STATS_EN`: 5 resolves including 2 mispredicts → `stat_branches`=5, `stat_mispred`=2. Assert `reset` → both read 0.
